// File: rtl/spi_reg_mode.sv
// spi_reg_mode: SPI slave exposing a register file with auto-incrementing
// addresses, per-frame latched SPI mode (cpol/cpha) and fast commands.
//
// Optional feature macro: SPI_REG_STATUS_EN
//   defined   -> the command-byte phase shifts out the status port
//   undefined -> the command-byte phase shifts out 0x00; status is unused
//
// Ports
//   clk, nrst           system clock, asynchronous active-low reset
//   cpol, cpha          SPI mode, latched at start of frame
//   sclk, nss, mosi     SPI inputs (asynchronous, synchronised here)
//   miso                SPI serial data out
//   reg_addr            current register address
//   reg_data_i          read data for reg_addr
//   reg_rd_stb          pulse: reg_data_i captured
//   reg_data_o          write data
//   reg_data_o_vld      pulse: write strobe
//   status              status byte shifted out during the command byte
//   fastcmd/_vld        fast-command code and strobe
//   frame_err           pulse: frame aborted mid-word
`timescale 1ns/1ps
module spi_reg_mode #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned REG_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic              reg_rd_stb,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_vld,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(REG_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(REG_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_SKIP} state_t;

  // Input synchronisers plus one edge-detect flop each for sclk and nss
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_nss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_nss_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sclk_sync <= '0;
      r_nss_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_nss_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_nss_d     <= r_nss_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_nss, w_mosi;
  logic w_rise, w_fall, w_sof, w_eof;
  logic w_lead, w_trail, w_sample, w_change;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_nss  = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  assign w_sof  = ~w_nss & r_nss_d;
  assign w_eof  = w_nss & ~r_nss_d;

  logic r_cpol, r_cpha;
  assign w_lead   = r_cpol ? w_fall : w_rise;
  assign w_trail  = r_cpol ? w_rise : w_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_change = r_cpha ? w_lead : w_trail;

  // Shift-register contents loaded at start of frame
  logic [REG_W-1:0] w_tx_init;
`ifdef SPI_REG_STATUS_EN
  assign w_tx_init = REG_W'(status) << (REG_W - 8);
`else
  logic w_unused_status;
  assign w_unused_status = ^status;
  assign w_tx_init       = '0;
`endif

  state_t            r_state;
  logic              r_write;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [REG_W-1:0]  r_rx, r_tx;
  logic              r_fresh;     // next change edge presents r_tx MSB without shifting
  logic              r_rd_pend;   // capture reg_data_i next cycle (reg_addr now valid)
  logic              r_inc_pend;  // increment reg_addr next cycle after a write
  logic              r_miso;
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_data_o;
  logic              r_data_o_vld, r_rd_stb, r_fastcmd_vld, r_frame_err;
  logic [5:0]        r_fastcmd;
  logic [REG_W-1:0]  w_rx_next;

  assign w_rx_next = {r_rx[REG_W-2:0], w_mosi};

  // Frame FSM and datapath
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= ST_IDLE;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_write       <= 1'b0;
      r_bit_cnt     <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_fresh       <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_inc_pend    <= 1'b0;
      r_miso        <= 1'b0;
      r_addr        <= '0;
      r_data_o      <= '0;
      r_data_o_vld  <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_fastcmd     <= '0;
      r_fastcmd_vld <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_data_o_vld  <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_fastcmd_vld <= 1'b0;
      r_frame_err   <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_inc_pend    <= 1'b0;

      if (r_inc_pend) r_addr <= r_addr + ADDR_W'(1);

      if (r_rd_pend) begin
        r_tx     <= reg_data_i;
        r_fresh  <= 1'b1;
        r_rd_stb <= 1'b1;
        r_addr   <= r_addr + ADDR_W'(1);
      end

      if (w_sof) begin
        r_state   <= ST_CMD;
        r_cpol    <= cpol;
        r_cpha    <= cpha;
        r_bit_cnt <= '0;
        r_tx      <= w_tx_init;
        r_fresh   <= cpha;
        r_miso    <= cpha ? 1'b0 : w_tx_init[REG_W-1];
        r_rd_pend <= 1'b0;
      end else if (w_eof) begin
        if ((r_state == ST_CMD || r_state == ST_DATA) && r_bit_cnt != '0)
          r_frame_err <= 1'b1;
        r_state <= ST_IDLE;
        r_miso  <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD, ST_DATA: begin
            if (w_sample) begin
              r_rx <= w_rx_next;
              if (r_state == ST_CMD && r_bit_cnt == LAST_CMD) begin
                r_bit_cnt <= '0;
                case (w_rx_next[7:6])
                  2'b00: begin
                    r_addr    <= w_rx_next[ADDR_W-1:0];
                    r_write   <= 1'b0;
                    r_rd_pend <= 1'b1;
                    r_state   <= ST_DATA;
                  end
                  2'b10: begin
                    r_addr  <= w_rx_next[ADDR_W-1:0];
                    r_write <= 1'b1;
                    r_state <= ST_DATA;
                  end
                  2'b11: begin
                    r_fastcmd     <= w_rx_next[5:0];
                    r_fastcmd_vld <= 1'b1;
                    r_state       <= ST_SKIP;
                    r_miso        <= 1'b0;
                  end
                  default: begin
                    r_state <= ST_SKIP;
                    r_miso  <= 1'b0;
                  end
                endcase
              end else if (r_state == ST_DATA && r_bit_cnt == LAST_WORD) begin
                r_bit_cnt <= '0;
                if (r_write) begin
                  r_data_o     <= w_rx_next;
                  r_data_o_vld <= 1'b1;
                  r_inc_pend   <= 1'b1;
                end else begin
                  r_rd_pend <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end else if (w_change) begin
              if (r_fresh) begin
                r_miso  <= r_tx[REG_W-1];
                r_fresh <= 1'b0;
              end else begin
                r_tx   <= {r_tx[REG_W-2:0], 1'b0};
                r_miso <= r_tx[REG_W-2];
              end
            end
          end
          ST_SKIP: r_miso <= 1'b0;
          ST_IDLE: r_miso <= 1'b0;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso           = r_miso;
  assign reg_addr       = r_addr;
  assign reg_rd_stb     = r_rd_stb;
  assign reg_data_o     = r_data_o;
  assign reg_data_o_vld = r_data_o_vld;
  assign fastcmd        = r_fastcmd;
  assign fastcmd_vld    = r_fastcmd_vld;
  assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_spi_reg_mode.sv
// Directed bench for spi_reg_mode: an 8-bit-register instance and a
// 16-bit-register instance share one SPI master driven from a single
// initial block; strobes are counted by a negedge monitor.
`timescale 1ns/1ps
module tb_spi_reg_mode;

  localparam int unsigned HALF = 80;  // SPI half period: 8 clk cycles
`ifdef SPI_REG_STATUS_EN
  localparam logic [7:0] EXP_STATUS = 8'h5A;
`else
  localparam logic [7:0] EXP_STATUS = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, cpol, cpha, sclk, nss, mosi, cur_cpha;
  logic [7:0] status;

  logic        miso8, rd_stb8, vld8, fcv8, ferr8;
  logic [2:0]  addr8;
  logic [7:0]  rd8, data_o8;
  logic [5:0]  fc8;
  logic        miso16, rd_stb16, vld16, fcv16, ferr16;
  logic [2:0]  addr16;
  logic [15:0] rd16, data_o16;
  logic [5:0]  fc16;

  logic [7:0]  mem8  [8];
  logic [15:0] mem16 [8];
  assign rd8  = mem8[addr8];
  assign rd16 = mem16[addr16];

  spi_reg_mode #(.ADDR_W(3), .REG_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .nrst(nrst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .nss(nss),
    .mosi(mosi), .miso(miso8), .reg_addr(addr8), .reg_data_i(rd8),
    .reg_rd_stb(rd_stb8), .reg_data_o(data_o8), .reg_data_o_vld(vld8),
    .status(status), .fastcmd(fc8), .fastcmd_vld(fcv8), .frame_err(ferr8)
  );

  spi_reg_mode #(.ADDR_W(3), .REG_W(16), .SYNC_STAGES(3)) u_dut16 (
    .clk(clk), .nrst(nrst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .nss(nss),
    .mosi(mosi), .miso(miso16), .reg_addr(addr16), .reg_data_i(rd16),
    .reg_rd_stb(rd_stb16), .reg_data_o(data_o16), .reg_data_o_vld(vld16),
    .status(status), .fastcmd(fc16), .fastcmd_vld(fcv16), .frame_err(ferr16)
  );

  // Strobe monitor
  int wr8_n = 0, wr16_n = 0, rd16_n = 0, fc8_n = 0, fc16_n = 0, fe8_n = 0, fe16_n = 0;
  logic [7:0] wr8_data = '0;
  logic [2:0] wr8_addr = '0;
  always @(negedge clk) begin
    if (vld8) begin
      wr8_n++;
      wr8_data = data_o8;
      wr8_addr = addr8;
    end
    if (vld16)    wr16_n++;
    if (rd_stb16) rd16_n++;
    if (fcv8)     fc8_n++;
    if (fcv16)    fc16_n++;
    if (ferr8)    fe8_n++;
    if (ferr16)   fe16_n++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    if (!cur_cpha) begin
      mosi = mo;
      #HALF;
      mi   = miso8;
      sclk = ~sclk;
      #HALF;
      sclk = ~sclk;
    end else begin
      sclk = ~sclk;
      mosi = mo;
      #HALF;
      mi   = miso8;
      sclk = ~sclk;
      #HALF;
    end
  endtask

  // Byte transfer observing miso of the 8-bit instance
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  // Byte transfer observing miso of the 16-bit instance
  task automatic spi_byte16(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      if (!cur_cpha) begin
        mosi = tx[i];
        #HALF;
        rx[i] = miso16;
        sclk  = ~sclk;
        #HALF;
        sclk  = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = tx[i];
        #HALF;
        rx[i] = miso16;
        sclk  = ~sclk;
        #HALF;
      end
    end
  endtask

  task automatic frame_begin(input logic pol, input logic pha);
    cpol     = pol;
    cpha     = pha;
    cur_cpha = pha;
    sclk     = pol;
    #HALF;
    nss = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    nss = 1'b1;
    #(2 * HALF);
  endtask

  initial begin
    logic [7:0] rx, b0, b1, b2, b3;
    logic       bit_rx;
    int s_wr8, s_wr16, s_rd16, s_fc8, s_fc16, s_fe8, s_fe16;

    nrst = 1'b0; sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; cur_cpha = 1'b0; status = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      mem8[i]  = 8'(i * 17);
      mem16[i] = 16'(i * 257);
    end
    mem8[6]  = 8'h96;
    mem16[7] = 16'h1234;
    mem16[0] = 16'hBEEF;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_miso8", 32'(miso8), 32'd0);
    chk("rst_miso16", 32'(miso16), 32'd0);
    chk("rst_addr8", 32'(addr8), 32'd0);
    chk("rst_data_o8", 32'(data_o8), 32'd0);
    chk("rst_data_o16", 32'(data_o16), 32'd0);
    chk("rst_strobes8", 32'({vld8, rd_stb8, fcv8, ferr8}), 32'd0);
    chk("rst_fastcmd8", 32'(fc8), 32'd0);
    nrst = 1'b1;
    repeat (6) @(posedge clk);

    // Mode 0 write: cmd 0x82, data 0xA5
    s_wr8 = wr8_n;
    frame_begin(1'b0, 1'b0);
    spi_byte(8'h82, rx);
    chk("t1_cmd_miso", 32'(rx), 32'(EXP_STATUS));
    spi_byte(8'hA5, rx);
    frame_end();
    chk("t1_wr_cnt", 32'(wr8_n - s_wr8), 32'd1);
    chk("t1_wr_data", 32'(wr8_data), 32'hA5);
    chk("t1_wr_addr", 32'(wr8_addr), 32'd2);
    chk("t1_addr_after", 32'(addr8), 32'd3);
    chk("t1_data_o", 32'(data_o8), 32'hA5);

    // Mode 3 read, 16-bit: cmd 0x07, address wraps 7 -> 0
    s_rd16 = rd16_n; s_wr16 = wr16_n;
    frame_begin(1'b1, 1'b1);
    spi_byte16(8'h07, rx);
    chk("t2_cmd_miso", 32'(rx), 32'(EXP_STATUS));
    repeat (4) @(posedge clk);
    chk("t2_addr_wrap", 32'(addr16), 32'd0);
    spi_byte16(8'h00, b0);
    spi_byte16(8'h00, b1);
    spi_byte16(8'h00, b2);
    spi_byte16(8'h00, b3);
    frame_end();
    chk("t2_byte0", 32'(b0), 32'h12);
    chk("t2_byte1", 32'(b1), 32'h34);
    chk("t2_byte2", 32'(b2), 32'hBE);
    chk("t2_byte3", 32'(b3), 32'hEF);
    chk("t2_addr_end", 32'(addr16), 32'd2);
    chk("t2_rd_cnt", 32'(rd16_n - s_rd16), 32'd3);
    chk("t2_no_wr16", 32'(wr16_n - s_wr16), 32'd0);

    // Mode 1 fast command 0xC5, trailing bytes ignored
    s_fc8 = fc8_n; s_fc16 = fc16_n; s_wr8 = wr8_n;
    frame_begin(1'b0, 1'b1);
    spi_byte(8'hC5, rx);
    chk("t3_cmd_miso", 32'(rx), 32'(EXP_STATUS));
    spi_byte(8'hFF, b0);
    spi_byte(8'h3C, b1);
    frame_end();
    chk("t3_skip_miso0", 32'(b0), 32'd0);
    chk("t3_skip_miso1", 32'(b1), 32'd0);
    chk("t3_fc_cnt", 32'(fc8_n - s_fc8), 32'd1);
    chk("t3_fastcmd", 32'(fc8), 32'h05);
    chk("t3_fc16_cnt", 32'(fc16_n - s_fc16), 32'd1);
    chk("t3_fastcmd16", 32'(fc16), 32'h05);
    chk("t3_no_wr", 32'(wr8_n - s_wr8), 32'd0);

    // Mode 2 reserved command: status byte out, then zeros
    frame_begin(1'b1, 1'b0);
    spi_byte(8'h40, rx);
    chk("t4_status_miso", 32'(rx), 32'(EXP_STATUS));
    spi_byte(8'hFF, b0);
    frame_end();
    chk("t4_skip_miso", 32'(b0), 32'd0);
    chk("t4_miso_idle", 32'(miso8), 32'd0);
    chk("t4_addr_kept", 32'(addr8), 32'd4);

    // Write aborted after 5 data bits
    s_fe8 = fe8_n; s_fe16 = fe16_n; s_wr8 = wr8_n;
    frame_begin(1'b0, 1'b0);
    spi_byte(8'h83, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_rx);
    frame_end();
    chk("t5_ferr_cnt", 32'(fe8_n - s_fe8), 32'd1);
    chk("t5_ferr16_cnt", 32'(fe16_n - s_fe16), 32'd1);
    chk("t5_no_wr", 32'(wr8_n - s_wr8), 32'd0);
    chk("t5_addr", 32'(addr8), 32'd3);

    // Reset mid-word, then clean frames
    s_fe8 = fe8_n;
    frame_begin(1'b0, 1'b0);
    spi_byte(8'h84, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, bit_rx);
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_addr", 32'(addr8), 32'd0);
    chk("t6_rst_miso", 32'(miso8), 32'd0);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    nss = 1'b1;
    repeat (20) @(posedge clk);
    chk("t6_no_ferr", 32'(fe8_n - s_fe8), 32'd0);
    s_wr8 = wr8_n;
    frame_begin(1'b0, 1'b0);
    spi_byte(8'h85, rx);
    spi_byte(8'h3C, rx);
    frame_end();
    chk("t6_wr_cnt", 32'(wr8_n - s_wr8), 32'd1);
    chk("t6_wr_data", 32'(wr8_data), 32'h3C);
    chk("t6_wr_addr", 32'(wr8_addr), 32'd5);
    chk("t6_addr_after", 32'(addr8), 32'd6);
    frame_begin(1'b0, 1'b0);
    spi_byte(8'h06, rx);
    spi_byte(8'h00, b0);
    frame_end();
    chk("t6_rd_data", 32'(b0), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
